// File: rtl/id_stage_pkg.sv
// Shared RV32I decode definitions for the ID stage: opcodes, ALU-class encodings,
// the canonical NOP, the control bundle and the decode/immediate helpers.
package id_stage_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ULA_ADD = 2'b00;
    localparam logic [1:0] ULA_BR  = 2'b01;
    localparam logic [1:0] ULA_R   = 2'b10;
    localparam logic [1:0] ULA_I   = 2'b11;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ula_src;
        logic       branch;
        logic [1:0] ula_op;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input logic [6:0] opcode);
        ctrl_t c;
        case (opcode)
            OP_R:      c = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ULA_R};
            OP_IMM:    c = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ULA_I};
            OP_LOAD:   c = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, ULA_ADD};
            OP_STORE:  c = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ULA_ADD};
            OP_BRANCH: c = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ULA_BR};
            default:   c = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
        endcase
        return c;
    endfunction

    function automatic logic [31:0] gen_imm(input logic [31:0] instr);
        logic [31:0] imm;
        case (instr[6:0])
            OP_IMM, OP_LOAD: imm = {{20{instr[31]}}, instr[31:20]};
            OP_STORE:        imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRANCH:       imm = {{19{instr[31]}}, instr[31], instr[7],
                                    instr[30:25], instr[11:8], 1'b0};
            default:         imm = 32'd0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/id_stage_register_file.sv
// 32x32 register file: two combinational read ports with write-through bypass,
// one synchronous write port, x0 hardwired to zero.
module register_file (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rd_addr1,
    input  logic [4:0]  rd_addr2,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data1,
    output logic [31:0] rd_data2
);

    logic [31:0] regs_r [32];

    // Storage; writes aimed at x0 are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= 32'd0;
            end
        end else if (wr_en && (wr_addr != 5'd0)) begin
            regs_r[wr_addr] <= wr_data;
        end
    end

    // Read port 1 with same-cycle write-back forwarding
    always_comb begin
        if (rd_addr1 == 5'd0) begin
            rd_data1 = 32'd0;
        end else if (wr_en && (wr_addr == rd_addr1)) begin
            rd_data1 = wr_data;
        end else begin
            rd_data1 = regs_r[rd_addr1];
        end
    end

    // Read port 2 with same-cycle write-back forwarding
    always_comb begin
        if (rd_addr2 == 5'd0) begin
            rd_data2 = 32'd0;
        end else if (wr_en && (wr_addr == rd_addr2)) begin
            rd_data2 = wr_data;
        end else begin
            rd_data2 = regs_r[rd_addr2];
        end
    end

endmodule

// File: rtl/id_stage.sv
// RV32I instruction-decode stage: IF/ID register, register file, control decode,
// immediate generation and load-use hazard detection feeding ID/EX.
module id_stage
    import id_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_pc_plus_4,
    input  logic [31:0] if_instr,
    input  logic        flush,
    input  logic        idex_MemRead,
    input  logic [4:0]  idex_rd,
    input  logic        wb_RegWrite,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        pc_write,
    output logic        ControlMux,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc_plus_4,
    output logic [31:0] id_reg_data1,
    output logic [31:0] id_reg_data2,
    output logic [31:0] id_immediate,
    output logic [4:0]  ifid_rs1,
    output logic [4:0]  ifid_rs2,
    output logic [4:0]  ifid_rd,
    output logic [2:0]  ifid_funct3,
    output logic        ifid_funct7_bit5,
    output logic        id_RegWrite,
    output logic        id_MemRead,
    output logic        id_MemWrite,
    output logic        id_MemtoReg,
    output logic        id_ULASrc,
    output logic        id_Branch,
    output logic [1:0]  id_ULAOp
);

    logic [31:0] ifid_instr_r;
    logic [31:0] ifid_pc_r;
    logic [31:0] ifid_pc_plus_4_r;
    logic [6:0]  opcode_s;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic        reads_rs2_s;
    logic        load_use_s;
    logic        stall_s;
    ctrl_t       ctrl_s;

    assign opcode_s = ifid_instr_r[6:0];
    assign rs1_s    = ifid_instr_r[19:15];
    assign rs2_s    = ifid_instr_r[24:20];

    // Load-use: a load in EX targets a register this instruction actually reads
    always_comb begin
        case (opcode_s)
            OP_R, OP_STORE, OP_BRANCH: reads_rs2_s = 1'b1;
            default:                   reads_rs2_s = 1'b0;
        endcase
        if (idex_MemRead && (idex_rd != 5'd0) &&
            ((idex_rd == rs1_s) || ((idex_rd == rs2_s) && reads_rs2_s))) begin
            load_use_s = 1'b1;
        end else begin
            load_use_s = 1'b0;
        end
    end

    // A taken branch squashes IF/ID, so it cancels any stall request
    assign stall_s    = load_use_s & ~flush;
    assign pc_write   = ~stall_s;
    assign ControlMux = load_use_s | flush;

    // IF/ID pipeline register: flush beats stall beats load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_instr_r     <= NOP_INSTR;
            ifid_pc_r        <= 32'd0;
            ifid_pc_plus_4_r <= 32'd0;
        end else if (flush) begin
            ifid_instr_r     <= NOP_INSTR;
            ifid_pc_r        <= 32'd0;
            ifid_pc_plus_4_r <= 32'd0;
        end else if (!stall_s) begin
            ifid_instr_r     <= if_instr;
            ifid_pc_r        <= if_pc;
            ifid_pc_plus_4_r <= if_pc_plus_4;
        end
    end

    register_file u_register_file (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr1 (rs1_s),
        .rd_addr2 (rs2_s),
        .wr_en    (wb_RegWrite),
        .wr_addr  (wb_rd),
        .wr_data  (wb_data),
        .rd_data1 (id_reg_data1),
        .rd_data2 (id_reg_data2)
    );

    assign ctrl_s       = decode_ctrl(opcode_s);
    assign id_immediate = gen_imm(ifid_instr_r);

    assign ifid_pc          = ifid_pc_r;
    assign ifid_pc_plus_4   = ifid_pc_plus_4_r;
    assign ifid_rs1         = rs1_s;
    assign ifid_rs2         = rs2_s;
    assign ifid_rd          = ifid_instr_r[11:7];
    assign ifid_funct3      = ifid_instr_r[14:12];
    assign ifid_funct7_bit5 = ifid_instr_r[30];

    assign id_RegWrite = ctrl_s.reg_write;
    assign id_MemRead  = ctrl_s.mem_read;
    assign id_MemWrite = ctrl_s.mem_write;
    assign id_MemtoReg = ctrl_s.mem_to_reg;
    assign id_ULASrc   = ctrl_s.ula_src;
    assign id_Branch   = ctrl_s.branch;
    assign id_ULAOp    = ctrl_s.ula_op;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: a behavioural model checked every negedge plus
// hand-computed literal expectations for the key scenarios.
module tb_id_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] if_pc, if_pc_plus_4, if_instr;
    logic        flush, idex_MemRead, wb_RegWrite;
    logic [4:0]  idex_rd, wb_rd;
    logic [31:0] wb_data;
    logic        pc_write, ControlMux;
    logic [31:0] ifid_pc, ifid_pc_plus_4, id_reg_data1, id_reg_data2, id_immediate;
    logic [4:0]  ifid_rs1, ifid_rs2, ifid_rd;
    logic [2:0]  ifid_funct3;
    logic        ifid_funct7_bit5;
    logic        id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg, id_ULASrc, id_Branch;
    logic [1:0]  id_ULAOp;

    id_stage dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pc_plus_4(if_pc_plus_4),
        .if_instr(if_instr), .flush(flush), .idex_MemRead(idex_MemRead), .idex_rd(idex_rd),
        .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_data(wb_data),
        .pc_write(pc_write), .ControlMux(ControlMux), .ifid_pc(ifid_pc),
        .ifid_pc_plus_4(ifid_pc_plus_4), .id_reg_data1(id_reg_data1),
        .id_reg_data2(id_reg_data2), .id_immediate(id_immediate), .ifid_rs1(ifid_rs1),
        .ifid_rs2(ifid_rs2), .ifid_rd(ifid_rd), .ifid_funct3(ifid_funct3),
        .ifid_funct7_bit5(ifid_funct7_bit5), .id_RegWrite(id_RegWrite),
        .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite), .id_MemtoReg(id_MemtoReg),
        .id_ULASrc(id_ULASrc), .id_Branch(id_Branch), .id_ULAOp(id_ULAOp)
    );

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] ADD_X6  = 32'h0002_8333; // add  x6,x5,x0
    localparam logic [31:0] ADDI_X7 = 32'h0010_0393; // addi x7,x0,1
    localparam logic [31:0] ADDI_X1 = 32'h0050_0093; // addi x1,x0,5 (rs2 field = 5)
    localparam logic [31:0] SW_I    = 32'hFE20_AE23; // sw   x2,-4(x1)
    localparam logic [31:0] BEQ_I   = 32'hFE00_0CE3; // beq  x0,x0,-8
    localparam logic [31:0] LW_I    = 32'h00C2_A403; // lw   x8,12(x5)
    localparam logic [31:0] LUI_I   = 32'h1234_5037; // lui: not decoded here

    int n_checks = 0;
    int n_errors = 0;
    logic check_en = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_instr, m_pc, m_pc4;
    logic [31:0] m_regs [32];
    logic [7:0]  ctrl_tbl [logic [6:0]];

    function automatic logic model_load_use(input logic [31:0] ins);
        int  rs1, rs2, hz;
        logic reads_rs2;
        rs1 = int'(ins[19:15]);
        rs2 = int'(ins[24:20]);
        hz  = int'(idex_rd);
        reads_rs2 = (ins[6:0] == 7'h33) || (ins[6:0] == 7'h23) || (ins[6:0] == 7'h63);
        return idex_MemRead && (hz != 0) && ((hz == rs1) || ((hz == rs2) && reads_rs2));
    endfunction

    function automatic logic [31:0] model_read(input int a);
        if (a == 0) return 32'd0;
        if (wb_RegWrite && (int'(wb_rd) == a)) return wb_data;
        return m_regs[a];
    endfunction

    function automatic logic [31:0] model_imm(input logic [31:0] ins);
        int v;
        v = 0;
        if (ins[6:0] == 7'h13 || ins[6:0] == 7'h03) begin
            v = int'(ins[31:20]);
            if (v >= 2048) v = v - 4096;
        end else if (ins[6:0] == 7'h23) begin
            v = int'(ins[31:25]) * 32 + int'(ins[11:7]);
            if (v >= 2048) v = v - 4096;
        end else if (ins[6:0] == 7'h63) begin
            v = int'(ins[31]) * 4096 + int'(ins[7]) * 2048
              + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
            if (v >= 4096) v = v - 8192;
        end
        return 32'(v);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_instr <= NOP;
            m_pc    <= 32'd0;
            m_pc4   <= 32'd0;
            for (int i = 0; i < 32; i++) m_regs[i] <= 32'd0;
        end else begin
            if (flush) begin
                m_instr <= NOP;
                m_pc    <= 32'd0;
                m_pc4   <= 32'd0;
            end else if (!model_load_use(m_instr)) begin
                m_instr <= if_instr;
                m_pc    <= if_pc;
                m_pc4   <= if_pc_plus_4;
            end
            if (wb_RegWrite && wb_rd != 5'd0) m_regs[wb_rd] <= wb_data;
        end
    end

    // Compare every output against the model once per cycle
    always @(negedge clk) begin
        if (check_en) begin
            logic       lu;
            logic [7:0] c;
            lu = model_load_use(m_instr);
            if (ctrl_tbl.exists(m_instr[6:0])) c = ctrl_tbl[m_instr[6:0]];
            else c = 8'd0;
            check("m_pc_write",  32'(pc_write),   32'(!(lu && !flush)));
            check("m_ctrlmux",   32'(ControlMux), 32'(lu || flush));
            check("m_ifid_pc",   ifid_pc,         m_pc);
            check("m_ifid_pc4",  ifid_pc_plus_4,  m_pc4);
            check("m_data1",     id_reg_data1,    model_read(int'(m_instr[19:15])));
            check("m_data2",     id_reg_data2,    model_read(int'(m_instr[24:20])));
            check("m_imm",       id_immediate,    model_imm(m_instr));
            check("m_fields",    32'({ifid_rs1, ifid_rs2, ifid_rd, ifid_funct3, ifid_funct7_bit5}),
                  32'({m_instr[19:15], m_instr[24:20], m_instr[11:7], m_instr[14:12], m_instr[30]}));
            check("m_ctrl",      32'({id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg,
                                      id_ULASrc, id_Branch, id_ULAOp}), 32'(c));
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        ctrl_tbl[7'h33] = 8'b1000_0010;
        ctrl_tbl[7'h13] = 8'b1000_1011;
        ctrl_tbl[7'h03] = 8'b1101_1000;
        ctrl_tbl[7'h23] = 8'b0010_1000;
        ctrl_tbl[7'h63] = 8'b0000_0101;

        rst_n = 1'b0; flush = 1'b0; idex_MemRead = 1'b0; idex_rd = 5'd0;
        wb_RegWrite = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
        if_pc = 32'd0; if_pc_plus_4 = 32'd0; if_instr = 32'd0;
        repeat (2) @(posedge clk);
        #1 check_en = 1'b1;

        // Outputs while in reset
        @(negedge clk);
        check("rst_pc_write", 32'(pc_write), 32'd1);
        check("rst_ctrlmux", 32'(ControlMux), 32'd0);
        check("rst_regwrite", 32'(id_RegWrite), 32'd1);
        check("rst_ulaop", 32'(id_ULAOp), 32'd3);
        check("rst_data1", id_reg_data1, 32'd0);

        // 1: release
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("t1_ifid_pc", ifid_pc, 32'd0);
        check("t1_ulaop", 32'(id_ULAOp), 32'd3);
        check("t1_rd", 32'(ifid_rd), 32'd0);
        check("t1_pc_write", 32'(pc_write), 32'd1);
        check("t1_ctrlmux", 32'(ControlMux), 32'd0);

        // 2: write x5 while fetching add x6,x5,x0
        if_pc = 32'h100; if_pc_plus_4 = 32'h104; if_instr = ADD_X6;
        wb_RegWrite = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
        @(posedge clk); #1 wb_RegWrite = 1'b0;
        @(negedge clk);
        check("t2_data1", id_reg_data1, 32'hDEADBEEF);
        check("t2_regwrite", 32'(id_RegWrite), 32'd1);
        check("t2_ulaop", 32'(id_ULAOp), 32'd2);
        check("t2_rd", 32'(ifid_rd), 32'd6);
        check("t2_pc", ifid_pc, 32'h100);
        #1 wb_RegWrite = 1'b1; wb_rd = 5'd5; wb_data = 32'hCAFEF00D;
        #1 check("t2_bypass", id_reg_data1, 32'hCAFEF00D);
        @(posedge clk); #1 wb_rd = 5'd0; wb_data = 32'hFFFFFFFF;
        #1 check("t2_x0_bypass", id_reg_data2, 32'd0);
        @(posedge clk); #1 wb_RegWrite = 1'b0;
        @(negedge clk);
        check("t2_x0_read", id_reg_data2, 32'd0);
        check("t2_stored", id_reg_data1, 32'hCAFEF00D);

        // 3: load-use stall for one cycle
        if_pc = 32'h104; if_pc_plus_4 = 32'h108; if_instr = ADDI_X7;
        idex_MemRead = 1'b1; idex_rd = 5'd5;
        #1 check("t3_ctrlmux", 32'(ControlMux), 32'd1);
        check("t3_pc_write", 32'(pc_write), 32'd0);
        @(posedge clk); #1 idex_MemRead = 1'b0;
        @(negedge clk);
        check("t3_held_pc", ifid_pc, 32'h100);
        check("t3_held_rd", 32'(ifid_rd), 32'd6);
        check("t3_release", 32'(pc_write), 32'd1);
        @(posedge clk); @(negedge clk);
        check("t3_next_pc", ifid_pc, 32'h104);
        check("t3_next_imm", id_immediate, 32'd1);

        // 4: flush together with a load-use
        if_pc = 32'h200; if_pc_plus_4 = 32'h204; if_instr = ADD_X6;
        @(posedge clk); #1 idex_MemRead = 1'b1; idex_rd = 5'd5; flush = 1'b1;
        if_pc = 32'h204; if_pc_plus_4 = 32'h208; if_instr = ADDI_X7;
        #1 check("t4_pc_write", 32'(pc_write), 32'd1);
        check("t4_ctrlmux", 32'(ControlMux), 32'd1);
        @(posedge clk); #1 flush = 1'b0; idex_MemRead = 1'b0;
        @(negedge clk);
        check("t4_pc", ifid_pc, 32'd0);
        check("t4_pc4", ifid_pc_plus_4, 32'd0);
        check("t4_rd", 32'(ifid_rd), 32'd0);
        check("t4_ulaop", 32'(id_ULAOp), 32'd3);

        // 5: immediates and decode
        if_pc = 32'h300; if_pc_plus_4 = 32'h304; if_instr = SW_I;
        @(posedge clk); @(negedge clk);
        check("t5_sw_imm", id_immediate, 32'hFFFFFFFC);
        check("t5_sw_memwrite", 32'(id_MemWrite), 32'd1);
        check("t5_sw_ulasrc", 32'(id_ULASrc), 32'd1);
        #1 idex_MemRead = 1'b1; idex_rd = 5'd2;
        #1 check("t5_sw_rs2_hazard", 32'(ControlMux), 32'd1);
        idex_MemRead = 1'b0;
        if_instr = BEQ_I;
        @(posedge clk); @(negedge clk);
        check("t5_beq_imm", id_immediate, 32'hFFFFFFF8);
        check("t5_beq_branch", 32'(id_Branch), 32'd1);
        check("t5_beq_ulaop", 32'(id_ULAOp), 32'd1);
        if_instr = LW_I;
        @(posedge clk); @(negedge clk);
        check("t5_lw_imm", id_immediate, 32'd12);
        check("t5_lw_memread", 32'(id_MemRead), 32'd1);
        if_instr = ADDI_X1;
        @(posedge clk); #1 idex_MemRead = 1'b1; idex_rd = 5'd5;
        @(negedge clk);
        check("t5_itype_no_stall", 32'(ControlMux), 32'd0);
        #1 idex_MemRead = 1'b0;
        if_instr = LUI_I;
        @(posedge clk); @(negedge clk);
        check("t5_unknown_regwrite", 32'(id_RegWrite), 32'd0);
        check("t5_unknown_imm", id_immediate, 32'd0);

        // 6: reset in the middle of a stall
        if_instr = ADD_X6; if_pc = 32'h400; if_pc_plus_4 = 32'h404;
        wb_RegWrite = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234;
        @(posedge clk); #1 wb_RegWrite = 1'b0; idex_MemRead = 1'b1; idex_rd = 5'd5;
        @(negedge clk);
        check("t6_stall", 32'(ControlMux), 32'd1);
        check("t6_data1", id_reg_data1, 32'h1234);
        #1 rst_n = 1'b0;
        #1 check("t6_rst_ctrlmux", 32'(ControlMux), 32'd0);
        check("t6_rst_pc_write", 32'(pc_write), 32'd1);
        check("t6_rst_ulaop", 32'(id_ULAOp), 32'd3);
        check("t6_rst_pc", ifid_pc, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1; idex_MemRead = 1'b0;
        @(posedge clk); @(negedge clk);
        check("t6_x5_cleared", id_reg_data1, 32'd0);
        check("t6_rd", 32'(ifid_rd), 32'd6);

        repeat (2) @(posedge clk);
        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
